// File: rtl/rev_alu_pkg.sv
// Shared types for the registered reversible ALU: opcodes, FSM states, legality helper.
package rev_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_NAND = 4'd6,
    OP_NOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_MUL  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd10;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/rev_adder_chain.sv
// WIDTH-bit reversible ripple chain: two Peres gates per bit for add, one DKG per bit for subtract.
module rev_adder_chain #(
  parameter int WIDTH = 4
) (
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  logic [WIDTH:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic hs, hc, ps, pc, ds, dc;
    // Peres pair forms a full adder: first gives x^y and xy, second folds in the carry.
    rev_peres_gate u_p0 (.a(x[i]), .b(y[i]), .c(1'b0), .q(hs), .r(hc));
    rev_peres_gate u_p1 (.a(hs),   .b(c[i]), .c(hc),   .q(ps), .r(pc));
    rev_dkg_gate   u_dk (.mode(1'b1), .x(x[i]), .y(y[i]), .bi(c[i]), .d(ds), .bo(dc));
    assign s[i]   = sub ? ds : ps;
    assign c[i+1] = sub ? dc : pc;
  end

  assign co = c[WIDTH];
endmodule

// File: rtl/rev_dkg_gate.sv
// DKG gate (4x4 reversible): mode=0 behaves as a full adder, mode=1 as a full subtractor x-y-bi.
module rev_dkg_gate (
  input  logic mode,
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = mode ? ((~x & y) | (~(x ^ y) & bi))
                   : ((x & y) | ((x ^ y) & bi));
endmodule

// File: rtl/rev_peres_gate.sv
// Peres gate (3x3 reversible): P=A passes through, Q=A^B, R=AB^C.
module rev_peres_gate (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic q,
  output logic r
);
  assign q = a ^ b;
  assign r = (a & b) ^ c;
endmodule

// File: rtl/rev_alu_seq.sv
// Registered reversible ALU: one op per valid/ready transaction, result held until accepted.
// Define REV_ALU_MUL_EN to build the iterative shift-add multiplier (opcode 9); otherwise 9 is illegal.
module rev_alu_seq
  import rev_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_c,
  output logic               flag_z,
  output logic               op_err
);
  localparam int RW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [3:0]       op_q, op_d;
  logic [RW-1:0]    result_q, result_d;
  logic             fc_q, fc_d, fz_q, fz_d, err_q, err_d;

`ifdef REV_ALU_MUL_EN
  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_END = CW'(WIDTH);
  logic [RW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic             add_sub, add_ci, add_co;
  logic [WIDTH-1:0] add_x, add_y, add_s;
  logic [RW-1:0]    exec_res;
  logic             exec_c, exec_err;

  always_comb begin
    add_x   = a_q;
    add_y   = b_q;
    add_ci  = cin_q;
    add_sub = (op_q == OP_SUB);
`ifdef REV_ALU_MUL_EN
    if (state_q == ST_MUL) begin
      add_x   = acc_q[RW-1:WIDTH];
      add_ci  = 1'b0;
      add_sub = 1'b0;
    end
`endif
  end

  rev_adder_chain #(.WIDTH(WIDTH)) u_chain (
    .sub(add_sub), .x(add_x), .y(add_y), .ci(add_ci), .s(add_s), .co(add_co)
  );

  always_comb begin
    exec_res = '0;
    exec_c   = 1'b0;
    exec_err = op_is_illegal(op_q);
    case (op_q)
      OP_ADD, OP_SUB: begin
        exec_res[WIDTH-1:0] = add_s;
        exec_c              = add_co;
      end
      OP_AND:  exec_res[WIDTH-1:0] = a_q & b_q;
      OP_OR:   exec_res[WIDTH-1:0] = a_q | b_q;
      OP_XOR:  exec_res[WIDTH-1:0] = a_q ^ b_q;
      OP_XNOR: exec_res[WIDTH-1:0] = ~(a_q ^ b_q);
      OP_NAND: exec_res[WIDTH-1:0] = ~(a_q & b_q);
      OP_NOR:  exec_res[WIDTH-1:0] = ~(a_q | b_q);
      OP_NOT:  exec_res[WIDTH-1:0] = ~a_q;
      default: exec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ov_d     = ov_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    op_d     = op_q;
    result_d = result_q;
    fc_d     = fc_q;
    fz_d     = fz_q;
    err_d    = err_q;
`ifdef REV_ALU_MUL_EN
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        cin_d   = cin;
        op_d    = op;
        state_d = ST_EXEC;
`ifdef REV_ALU_MUL_EN
        acc_d = '0;
        cnt_d = '0;
        if (op == OP_MUL) state_d = ST_MUL;
`endif
      end
      ST_EXEC: begin
        result_d = exec_res;
        fc_d     = exec_c;
        fz_d     = (exec_res == '0);
        err_d    = exec_err;
        state_d  = ST_DONE;
      end
`ifdef REV_ALU_MUL_EN
      ST_MUL: if (cnt_q == CNT_END) begin
        result_d = acc_q;
        fc_d     = 1'b0;
        fz_d     = (acc_q == '0);
        err_d    = 1'b0;
        state_d  = ST_DONE;
      end else begin
        // Adding b into the top half then shifting right is the same as adding b<<count.
        acc_d = a_q[0] ? {add_co, add_s, acc_q[WIDTH-1:1]} : {1'b0, acc_q[RW-1:1]};
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CW'(1);
      end
`endif
      ST_DONE: begin
        // out_valid trails the result registers by one edge, so data is settled when offered.
        ov_d = 1'b1;
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b1;
      ov_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      op_q       <= '0;
      result_q   <= '0;
      fc_q       <= 1'b0;
      fz_q       <= 1'b0;
      err_q      <= 1'b0;
`ifdef REV_ALU_MUL_EN
      acc_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      ov_q       <= ov_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      op_q       <= op_d;
      result_q   <= result_d;
      fc_q       <= fc_d;
      fz_q       <= fz_d;
      err_q      <= err_d;
`ifdef REV_ALU_MUL_EN
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = ov_q;
  assign result    = result_q;
  assign flag_c    = fc_q;
  assign flag_z    = fz_q;
  assign op_err    = err_q;

endmodule

// File: tb/tb_rev_alu_seq.sv
// Bench for rev_alu_seq (WIDTH=4): directed vector table, multi-cycle corner sequences, random ops vs reference model.
module tb_rev_alu_seq;
  localparam int W = 4;
`ifdef REV_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           cin = 1'b0;
  logic [3:0]     op = '0;
  logic [W-1:0]   a = '0, b = '0;
  logic           in_ready, out_valid, flag_c, flag_z, op_err;
  logic [2*W-1:0] result;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       err;
    int         lat;
  } vec_t;

  always #5 clk = ~clk;

  rev_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_c(flag_c), .flag_z(flag_z), .op_err(op_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the opcode definitions.
  function automatic void ref_model(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y,
                                    input logic ci, output logic [7:0] res, output logic c,
                                    output logic z, output logic err, output int lat);
    int xv, yv, t;
    xv = int'(x);
    yv = int'(y);
    res = '0; c = 1'b0; err = 1'b0; lat = 2;
    case (o)
      4'd0: begin t = xv + yv + int'(ci); res = 8'(t % 16); c = (t >= 16); end
      4'd1: begin t = xv - yv - int'(ci); res = 8'((t + 32) % 16); c = (t < 0); end
      4'd2: res = {4'h0, x & y};
      4'd3: res = {4'h0, x | y};
      4'd4: res = {4'h0, x ^ y};
      4'd5: res = {4'h0, ~(x ^ y)};
      4'd6: res = {4'h0, ~(x & y)};
      4'd7: res = {4'h0, ~(x | y)};
      4'd8: res = {4'h0, ~x};
      4'd9: if (MUL_EN) begin res = 8'(xv * yv); lat = W + 2; end else err = 1'b1;
      default: err = 1'b1;
    endcase
    z = (res == 8'h00);
  endfunction

  task automatic send(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y,
                      input logic ci, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("send.in_ready", 32'(in_ready), 32'd1);
    op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    op = 4'($urandom_range(15)); a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!out_valid && lat < 50);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input string tag, input logic [3:0] o, input logic [3:0] x,
                         input logic [3:0] y, input logic ci, input logic [7:0] er,
                         input logic ec, input logic ez, input logic ee, input int el);
    int lat;
    send(o, x, y, ci, lat);
    chk({tag, ".latency"}, 32'(lat), 32'(el));
    chk({tag, ".result"},  32'(result), 32'(er));
    chk({tag, ".flag_c"},  32'(flag_c), 32'(ec));
    chk({tag, ".flag_z"},  32'(flag_z), 32'(ez));
    chk({tag, ".op_err"},  32'(op_err), 32'(ee));
    ack();
    chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v[15];
    logic [3:0] o, x, y;
    logic       ci, ec, ez, ee;
    logic [7:0] er;
    int         el, lat;
    bit         saw;

    v[0]  = '{4'h0, 4'hF, 4'h1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2};
    v[1]  = '{4'h1, 4'h3, 4'h5, 1'b1, 8'h0D, 1'b1, 1'b0, 1'b0, 2};
    v[2]  = '{4'h6, 4'hA, 4'h6, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 2};
    if (MUL_EN) v[3] = '{4'h9, 4'hF, 4'hF, 1'b0, 8'hE1, 1'b0, 1'b0, 1'b0, 6};
    else        v[3] = '{4'h9, 4'hF, 4'hF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2};
    v[4]  = '{4'h0, 4'h2, 4'h3, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 2};
    v[5]  = '{4'h5, 4'h5, 4'h3, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 2};
    v[6]  = '{4'h8, 4'hA, 4'h3, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 2};
    v[7]  = '{4'hC, 4'h7, 4'h7, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 2};
    v[8]  = '{4'h3, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2};
    v[9]  = '{4'h1, 4'h0, 4'h0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 2};
    v[10] = '{4'h0, 4'hF, 4'hF, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 2};
    if (MUL_EN) v[11] = '{4'h9, 4'h0, 4'h7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 6};
    else        v[11] = '{4'h9, 4'h0, 4'h7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2};
    v[12] = '{4'h2, 4'hC, 4'hA, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 2};
    v[13] = '{4'h7, 4'h5, 4'h2, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 2};
    v[14] = '{4'h4, 4'hF, 4'hF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2};

    // Reset held with a request pending: nothing may be captured.
    rst_n = 1'b0; in_valid = 1'b1; op = 4'h0; a = 4'hF; b = 4'h1;
    repeat (3) @(negedge clk);
    chk("reset.in_ready",  32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.result",    32'(result), 32'd0);
    chk("reset.flag_c",    32'(flag_c), 32'd0);
    chk("reset.flag_z",    32'(flag_z), 32'd0);
    chk("reset.op_err",    32'(op_err), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset.no_capture", 32'(out_valid), 32'd0);

    for (int i = 0; i < 15; i++)
      run_vec($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].cin,
              v[i].res, v[i].c, v[i].z, v[i].err, v[i].lat);

    // Backpressure: DONE holds with stable outputs and ignores new requests.
    send(4'h4, 4'h5, 4'h3, 1'b0, lat);
    chk("bp.latency", 32'(lat), 32'd2);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = 4'h0; a = 4'h1; b = 4'h1;
      @(negedge clk);
      chk("bp.result",    32'(result), 32'h06);
      chk("bp.in_ready",  32'(in_ready), 32'd0);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    ack();
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("bp.no_stray_capture", 32'(out_valid), 32'd0);

    // Reset in the middle of a MUL (or of the illegal-op path when compiled out).
    saw = 1'b0;
    op = 4'h9; a = 4'hF; b = 4'hF; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (MUL_EN ? 3 : 1) begin
      @(posedge clk);
      #1 if (out_valid) saw = 1'b1;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready",  32'(in_ready), 32'd1);
    chk("midrst.result",    32'(result), 32'd0);
    chk("midrst.flag_z",    32'(flag_z), 32'd0);
    chk("midrst.op_err",    32'(op_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("midrst.no_valid_pulse", 32'(saw), 32'd0);
    run_vec("postrst.add", 4'h0, 4'h2, 4'h3, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 2);

    for (int i = 0; i < 60; i++) begin
      o  = (i % 4 == 0) ? 4'h9 : 4'($urandom_range(15));
      x  = 4'($urandom);
      y  = 4'($urandom);
      ci = 1'($urandom);
      ref_model(o, x, y, ci, er, ec, ez, ee, el);
      run_vec($sformatf("rnd%0d_op%0d", i, o), o, x, y, ci, er, ec, ez, ee, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
